mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data load-store) arbiter onto one shared memory port.
// Grant takes one edge; completion is combinational pass-through; requesters stall via busywait.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_read,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_readdata,
  output logic        instr_busywait,
  input  logic [3:0]  data_read,
  input  logic [2:0]  data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        data_busywait,
  output logic [3:0]  mem_read,
  output logic [2:0]  mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  localparam logic [2:0] LIMIT     = 3'(STARVE_LIMIT);
  localparam logic [3:0] WORD_LOAD = 4'b1010;

  state_t      state, state_nxt;
  logic [2:0]  starve_cnt;
  logic [31:0] lat_addr;
  logic [3:0]  lat_read;
  logic [2:0]  lat_write;
  logic [31:0] lat_wdata;
  logic [31:0] instr_rdata_q;
  logic [31:0] data_rdata_q;

  logic i_req, d_req, grant_i, grant_d, mem_done;

  assign i_req    = instr_read;
  assign d_req    = data_read[3] | data_write[2];
  // Data side normally wins; a starved fetch port overrides it once.
  assign grant_i  = i_req & (~d_req | (starve_cnt == LIMIT));
  assign grant_d  = d_req & ~grant_i;
  assign mem_done = ~mem_busywait;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_i)      state_nxt = SERVE_I;
        else if (grant_d) state_nxt = SERVE_D;
      end
      SERVE_I, SERVE_D: begin
        if (mem_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt    <= '0;
      lat_addr      <= '0;
      lat_read      <= '0;
      lat_write     <= '0;
      lat_wdata     <= '0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      if (state == IDLE) begin
        if (grant_i) begin
          lat_addr   <= instr_addr;
          lat_read   <= WORD_LOAD;
          lat_write  <= '0;
          lat_wdata  <= '0;
          starve_cnt <= '0;
        end else if (grant_d) begin
          lat_addr  <= data_addr;
          lat_read  <= data_read;
          lat_write <= data_write;
          lat_wdata <= data_writedata;
          if (i_req && (starve_cnt < LIMIT)) starve_cnt <= starve_cnt + 3'd1;
        end
      end
      if ((state == SERVE_I) && mem_done) instr_rdata_q <= mem_readdata;
      // Stores complete without touching the load-data holding register.
      if ((state == SERVE_D) && mem_done && lat_read[3]) data_rdata_q <= mem_readdata;
    end
  end

  always_comb begin
    mem_read       = '0;
    mem_write      = '0;
    mem_addr       = '0;
    mem_writedata  = '0;
    instr_busywait = i_req;
    data_busywait  = d_req;
    instr_readdata = instr_rdata_q;
    data_readdata  = data_rdata_q;
    case (state)
      SERVE_I: begin
        mem_read       = WORD_LOAD;
        mem_addr       = lat_addr;
        instr_busywait = ~mem_done;
        if (mem_done) instr_readdata = mem_readdata;
      end
      SERVE_D: begin
        mem_read      = lat_read;
        mem_write     = lat_write;
        mem_addr      = lat_addr;
        mem_writedata = lat_wdata;
        data_busywait = ~mem_done;
        if (mem_done && lat_read[3]) data_readdata = mem_readdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a wait-state memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_read = 1'b0;
  logic [31:0] instr_addr = '0;
  logic [31:0] instr_readdata;
  logic        instr_busywait;
  logic [3:0]  data_read = '0;
  logic [2:0]  data_write = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_writedata = '0;
  logic [31:0] data_readdata;
  logic        data_busywait;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int checks = 0;
  int errors = 0;

  logic [3:0]  mem_wait = '0;
  logic [3:0]  wcnt = '0;
  logic [31:0] mem_rdata = '0;
  logic        cmd_active;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .instr_read(instr_read), .instr_addr(instr_addr),
    .instr_readdata(instr_readdata), .instr_busywait(instr_busywait),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_writedata(data_writedata), .data_readdata(data_readdata),
    .data_busywait(data_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
  );

  always #5 clk = ~clk;

  // Memory stays busy for mem_wait cycles of any active command, then completes.
  assign cmd_active   = mem_read[3] | mem_write[2];
  assign mem_busywait = cmd_active && (wcnt < mem_wait);
  assign mem_readdata = mem_rdata;
  always @(posedge clk) wcnt <= (cmd_active && mem_busywait) ? wcnt + 4'd1 : 4'd0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++; if (mem_read !== 4'b0000) begin errors++; $display("FAIL rst_mem_read: got %h expected 0", mem_read); end
    checks++; if (mem_write !== 3'b000) begin errors++; $display("FAIL rst_mem_write: got %h expected 0", mem_write); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_writedata !== 32'h0) begin errors++; $display("FAIL rst_mem_writedata: got %h expected 0", mem_writedata); end
    checks++; if (instr_readdata !== 32'h0) begin errors++; $display("FAIL rst_instr_readdata: got %h expected 0", instr_readdata); end
    checks++; if (data_readdata !== 32'h0) begin errors++; $display("FAIL rst_data_readdata: got %h expected 0", data_readdata); end
    checks++; if ({instr_busywait, data_busywait} !== 2'b00) begin errors++; $display("FAIL rst_busywait: got %b expected 00", {instr_busywait, data_busywait}); end
    next_cycle();
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_instr_only();
    mem_wait   = 4'd2;
    mem_rdata  = 32'h0000_10B7;
    instr_read = 1'b1;
    instr_addr = 32'h10;
    sample();
    checks++; if (instr_busywait !== 1'b1) begin errors++; $display("FAIL ionly_idle_busy: got %b expected 1", instr_busywait); end
    checks++; if (mem_read !== 4'b0000) begin errors++; $display("FAIL ionly_idle_mem_read: got %h expected 0", mem_read); end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      sample();
      checks++; if (mem_read !== 4'b1010) begin errors++; $display("FAIL ionly_mem_read[%0d]: got %b expected 1010", k, mem_read); end
      checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL ionly_mem_addr[%0d]: got %h expected 10", k, mem_addr); end
      checks++; if (instr_busywait !== (k < 2)) begin errors++; $display("FAIL ionly_busy[%0d]: got %b expected %b", k, instr_busywait, (k < 2)); end
    end
    checks++; if (instr_readdata !== 32'h0000_10B7) begin errors++; $display("FAIL ionly_readdata: got %h expected 000010b7", instr_readdata); end
    next_cycle();
    instr_read = 1'b0;
    mem_rdata  = 32'hFFFF_FFFF;
    sample();
    checks++; if (instr_readdata !== 32'h0000_10B7) begin errors++; $display("FAIL ionly_hold: got %h expected 000010b7", instr_readdata); end
    checks++; if (mem_read !== 4'b0000) begin errors++; $display("FAIL ionly_after_mem_read: got %h expected 0", mem_read); end
    mem_wait = 4'd0;
    next_cycle();
  endtask

  task automatic test_simultaneous();
    mem_rdata  = 32'hAAAA_5555;
    instr_read = 1'b1;
    instr_addr = 32'h24;
    data_read  = 4'b1010;
    data_addr  = 32'h100;
    sample();
    checks++; if ({instr_busywait, data_busywait} !== 2'b11) begin errors++; $display("FAIL sim_idle_busy: got %b expected 11", {instr_busywait, data_busywait}); end
    next_cycle();
    sample();
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL sim_d_first_addr: got %h expected 100", mem_addr); end
    checks++; if (data_busywait !== 1'b0) begin errors++; $display("FAIL sim_d_busy: got %b expected 0", data_busywait); end
    checks++; if (data_readdata !== 32'hAAAA_5555) begin errors++; $display("FAIL sim_d_readdata: got %h expected aaaa5555", data_readdata); end
    checks++; if (instr_busywait !== 1'b1) begin errors++; $display("FAIL sim_i_stalled: got %b expected 1", instr_busywait); end
    checks++; if (instr_readdata !== 32'h0000_10B7) begin errors++; $display("FAIL sim_i_hold: got %h expected 000010b7", instr_readdata); end
    next_cycle();
    data_read = 4'b0000;
    mem_rdata = 32'h1234_5678;
    sample();
    checks++; if (mem_read !== 4'b0000) begin errors++; $display("FAIL sim_gap_mem_read: got %h expected 0", mem_read); end
    checks++; if (instr_busywait !== 1'b1) begin errors++; $display("FAIL sim_gap_i_busy: got %b expected 1", instr_busywait); end
    checks++; if (data_readdata !== 32'hAAAA_5555) begin errors++; $display("FAIL sim_gap_d_hold: got %h expected aaaa5555", data_readdata); end
    next_cycle();
    sample();
    checks++; if (mem_addr !== 32'h24 || mem_read !== 4'b1010) begin errors++; $display("FAIL sim_i_cmd: got %h/%b expected 24/1010", mem_addr, mem_read); end
    checks++; if (instr_busywait !== 1'b0) begin errors++; $display("FAIL sim_i_busy: got %b expected 0", instr_busywait); end
    checks++; if (instr_readdata !== 32'h1234_5678) begin errors++; $display("FAIL sim_i_readdata: got %h expected 12345678", instr_readdata); end
    next_cycle();
    instr_read = 1'b0;
    sample();
    checks++; if (instr_readdata !== 32'h1234_5678) begin errors++; $display("FAIL sim_i_hold_after: got %h expected 12345678", instr_readdata); end
    next_cycle();
  endtask

  task automatic test_store();
    mem_rdata      = 32'h5555_5555;
    data_write     = 3'b110;
    data_addr      = 32'h200;
    data_writedata = 32'hDEAD_BEEF;
    sample();
    checks++; if (mem_write !== 3'b000 || data_busywait !== 1'b1) begin errors++; $display("FAIL st_idle: got %b/%b expected 000/1", mem_write, data_busywait); end
    next_cycle();
    sample();
    checks++; if (mem_write !== 3'b110) begin errors++; $display("FAIL st_mem_write: got %b expected 110", mem_write); end
    checks++; if (mem_writedata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_writedata: got %h expected deadbeef", mem_writedata); end
    checks++; if (mem_addr !== 32'h200 || mem_read !== 4'b0000) begin errors++; $display("FAIL st_addr_read: got %h/%b expected 200/0000", mem_addr, mem_read); end
    checks++; if (data_busywait !== 1'b0) begin errors++; $display("FAIL st_busy: got %b expected 0", data_busywait); end
    checks++; if (data_readdata !== 32'hAAAA_5555) begin errors++; $display("FAIL st_readdata_pass: got %h expected aaaa5555", data_readdata); end
    next_cycle();
    data_write = 3'b000;
    sample();
    checks++; if (mem_write !== 3'b000 || mem_writedata !== 32'h0) begin errors++; $display("FAIL st_one_cycle: got %b/%h expected 000/0", mem_write, mem_writedata); end
    checks++; if (data_readdata !== 32'hAAAA_5555) begin errors++; $display("FAIL st_readdata_hold: got %h expected aaaa5555", data_readdata); end
    next_cycle();
  endtask

  task automatic test_mid_change();
    mem_wait       = 4'd2;
    data_write     = 3'b110;
    data_addr      = 32'h200;
    data_writedata = 32'hCAFE_F00D;
    sample();
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      if (k == 0) begin
        data_addr      = 32'h300;
        data_write     = 3'b000;
        data_writedata = 32'h0;
      end
      sample();
      checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL mid_addr[%0d]: got %h expected 200", k, mem_addr); end
      checks++; if (mem_write !== 3'b110 || mem_writedata !== 32'hCAFE_F00D) begin errors++; $display("FAIL mid_cmd[%0d]: got %b/%h expected 110/cafef00d", k, mem_write, mem_writedata); end
      checks++; if (data_busywait !== (k < 2)) begin errors++; $display("FAIL mid_busy[%0d]: got %b expected %b", k, data_busywait, (k < 2)); end
    end
    next_cycle();
    sample();
    checks++; if (mem_write !== 3'b000) begin errors++; $display("FAIL mid_done_idle: got %b expected 000", mem_write); end
    mem_wait = 4'd0;
    next_cycle();
  endtask

  task automatic test_starvation();
    logic exp_i;
    instr_read     = 1'b1;
    instr_addr     = 32'h40;
    data_write     = 3'b110;
    data_addr      = 32'h280;
    data_writedata = 32'h0000_0011;
    for (int g = 0; g < 6; g++) begin
      sample();
      checks++; if (mem_read !== 4'b0000 || mem_write !== 3'b000) begin errors++; $display("FAIL starve_idle[%0d]: got %b/%b expected 0000/000", g, mem_read, mem_write); end
      next_cycle();
      exp_i = (g == 4);
      sample();
      checks++; if (mem_read !== (exp_i ? 4'b1010 : 4'b0000)) begin errors++; $display("FAIL starve_grant_read[%0d]: got %b expected %b", g, mem_read, (exp_i ? 4'b1010 : 4'b0000)); end
      checks++; if (mem_write !== (exp_i ? 3'b000 : 3'b110)) begin errors++; $display("FAIL starve_grant_write[%0d]: got %b expected %b", g, mem_write, (exp_i ? 3'b000 : 3'b110)); end
      next_cycle();
    end
    instr_read = 1'b0;
    data_write = 3'b000;
    sample();
    checks++; if (mem_read !== 4'b0000 || mem_write !== 3'b000) begin errors++; $display("FAIL starve_end: got %b/%b expected 0000/000", mem_read, mem_write); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    mem_wait  = 4'd5;
    mem_rdata = 32'h0000_0077;
    data_read = 4'b1010;
    data_addr = 32'h100;
    next_cycle();
    sample();
    checks++; if (mem_read !== 4'b1010 || data_busywait !== 1'b1) begin errors++; $display("FAIL rmid_busy_serve: got %b/%b expected 1010/1", mem_read, data_busywait); end
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++; if (mem_read !== 4'b0000 || mem_write !== 3'b000) begin errors++; $display("FAIL rmid_async_cmd: got %b/%b expected 0000/000", mem_read, mem_write); end
    checks++; if (data_readdata !== 32'h0 || instr_readdata !== 32'h0) begin errors++; $display("FAIL rmid_async_rdata: got %h/%h expected 0/0", data_readdata, instr_readdata); end
    checks++; if (data_busywait !== 1'b1) begin errors++; $display("FAIL rmid_pending_busy: got %b expected 1", data_busywait); end
    mem_wait = 4'd0;
    next_cycle();
    sample();
    reset = 1'b1;
    #1;
    checks++; if (mem_read !== 4'b0000) begin errors++; $display("FAIL rmid_release_idle: got %b expected 0000", mem_read); end
    next_cycle();
    checks++; if (mem_read !== 4'b1010 || mem_addr !== 32'h100) begin errors++; $display("FAIL rmid_regrant: got %b/%h expected 1010/100", mem_read, mem_addr); end
    checks++; if (data_busywait !== 1'b0 || data_readdata !== 32'h77) begin errors++; $display("FAIL rmid_complete: got %b/%h expected 0/77", data_busywait, data_readdata); end
    next_cycle();
    data_read = 4'b0000;
    sample();
    checks++; if (data_readdata !== 32'h77) begin errors++; $display("FAIL rmid_hold: got %h expected 77", data_readdata); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_instr_only();
    test_simultaneous();
    test_store();
    test_mid_change();
    test_starvation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
